// File: rtl/axi_sram_master.sv
// Single-outstanding AXI-lite style master: turns one local read/write command into
// AW->W->B or AR->R channel phases, with a per-phase wait-state timeout.
module axi_sram_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        aclk,
  input  logic        areset_n,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,

  output logic        rsp_valid,
  output logic        rsp_ok,
  output logic        rsp_timeout,
  output logic [31:0] rsp_rdata,

  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,

  output logic [31:0] wdata,
  output logic        wvalid,
  input  logic        wready,

  input  logic        bvalid,
  input  logic        bresp,
  output logic        bready,

  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,

  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StAr,
    StR,
    StRsp
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] wait_q;
  logic        hs;
  logic        in_phase;
  logic        expire;

  always_comb begin
    hs = 1'b0;
    unique case (state_q)
      StAw:    hs = awready;
      StW:     hs = wready;
      StB:     hs = bvalid;
      StAr:    hs = arready;
      StR:     hs = rvalid;
      default: hs = 1'b0;
    endcase
  end

  assign in_phase = state_q inside {StAw, StW, StB, StAr, StR};
  // Expire on the cycle whose increment would reach the limit, so valid is high TIMEOUT cycles.
  assign expire = in_phase && !hs && (TIMEOUT != 0) && ((32'(wait_q) + 32'd1) == TIMEOUT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd_valid) state_d = cmd_write ? StAw : StAr;
      StAw: begin
        if (hs)          state_d = StW;
        else if (expire) state_d = StRsp;
      end
      StW: begin
        if (hs)          state_d = StB;
        else if (expire) state_d = StRsp;
      end
      StB:    if (hs || expire) state_d = StRsp;
      StAr: begin
        if (hs)          state_d = StR;
        else if (expire) state_d = StRsp;
      end
      StR:    if (hs || expire) state_d = StRsp;
      StRsp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      cmd_ready   <= 1'b1;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_ok      <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
      awaddr      <= '0;
      wdata       <= '0;
      araddr      <= '0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (in_phase && (wait_q != 16'hFFFF)) begin
        wait_q <= wait_q + 16'd1;
      end

      // Channel strobes are registered copies of the next-state decode.
      cmd_ready <= (state_d == StIdle);
      awvalid   <= (state_d == StAw);
      wvalid    <= (state_d == StW);
      bready    <= (state_d == StB);
      arvalid   <= (state_d == StAr);
      rready    <= (state_d == StR);
      rsp_valid <= (state_d == StRsp);

      if (state_q == StIdle && cmd_valid) begin
        if (cmd_write) begin
          awaddr <= cmd_addr;
          wdata  <= cmd_wdata;
        end else begin
          araddr <= cmd_addr;
        end
      end

      if (state_d == StRsp) begin
        if (expire) begin
          rsp_ok      <= 1'b0;
          rsp_timeout <= 1'b1;
          rsp_rdata   <= '0;
        end else if (state_q == StB) begin
          rsp_ok      <= bresp;
          rsp_timeout <= 1'b0;
          rsp_rdata   <= '0;
        end else begin
          rsp_ok      <= 1'b1;
          rsp_timeout <= 1'b0;
          rsp_rdata   <= rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_master.sv
// Directed bench for axi_sram_master: a delay-programmable slave model, a vector table
// of transactions with hand-computed results, and hand-written reset sequences.
module tb_axi_sram_master;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ok, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bresp, bready;
  logic        arvalid, arready, rvalid, rready;

  int checks = 0;
  int errors = 0;

  // Slave model knobs: cycles the valid must be seen before the slave responds.
  int aw_d, w_d, b_d, ar_d, r_d;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic        bresp_v;
  logic [31:0] rdata_v;

  axi_sram_master #(.TIMEOUT(8)) dut (
    .aclk        (aclk),
    .areset_n    (areset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ok      (rsp_ok),
    .rsp_timeout (rsp_timeout),
    .rsp_rdata   (rsp_rdata),
    .awaddr      (awaddr),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wvalid      (wvalid),
    .wready      (wready),
    .bvalid      (bvalid),
    .bresp       (bresp),
    .bready      (bready),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .rready      (rready)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    awready = awvalid && (aw_cnt >= aw_d);
    wready  = wvalid  && (w_cnt  >= w_d);
    bvalid  = bready  && (b_cnt  >= b_d);
    bresp   = bresp_v;
    arready = arvalid && (ar_cnt >= ar_d);
    rvalid  = rready  && (r_cnt  >= r_d);
    rdata   = rdata_v;
  end

  always @(posedge aclk) begin
    aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
    w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
    b_cnt  <= (bready  && !bvalid)  ? b_cnt  + 1 : 0;
    ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
    r_cnt  <= (rready  && !rvalid)  ? r_cnt  + 1 : 0;
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wd;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic        bresp;
    logic [31:0] rd;
    int          lat;     // cycle index of rsp_valid, accept cycle = 1
    logic        ok;
    logic        to;
    logic [31:0] exp_rd;
    int          phase;   // cycles the address valid stays high
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc;
    int          ph;
    logic [31:0] a0, cur;
    logic        bad_addr, overlap, bad_wd, seen;
    aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d; ar_d = v.ar_d; r_d = v.r_d;
    bresp_v = v.bresp;
    rdata_v = v.rd;
    @(negedge aclk);
    chk($sformatf("v%0d cmd_ready idle", idx), 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wd;
    cyc = 1; ph = 0; a0 = '0; bad_addr = 0; overlap = 0; bad_wd = 0; seen = 0;
    while (cyc < 40 && !seen) begin
      @(negedge aclk);
      cyc++;
      cmd_valid = 1'b0;
      if (awvalid || arvalid) begin
        cur = awvalid ? awaddr : araddr;
        ph++;
        if (ph == 1) a0 = cur;
        else if (cur != a0) bad_addr = 1;
      end
      if (awvalid && wvalid) overlap = 1;
      if (wvalid && wdata != v.wd) bad_wd = 1;
      if (rsp_valid) seen = 1;
    end
    chk($sformatf("v%0d latency", idx), seen ? 32'(cyc) : 32'd0, 32'(v.lat));
    chk($sformatf("v%0d rsp_ok", idx), 32'(rsp_ok), 32'(v.ok));
    chk($sformatf("v%0d rsp_timeout", idx), 32'(rsp_timeout), 32'(v.to));
    chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rd);
    chk($sformatf("v%0d addr valid cycles", idx), 32'(ph), 32'(v.phase));
    chk($sformatf("v%0d addr value", idx), a0, v.addr);
    chk($sformatf("v%0d addr stable", idx), 32'(bad_addr), 32'd0);
    chk($sformatf("v%0d wvalid during aw", idx), 32'(overlap), 32'd0);
    chk($sformatf("v%0d wdata", idx), 32'(bad_wd), 32'd0);
    @(negedge aclk);
    chk($sformatf("v%0d rsp_valid one cycle", idx), 32'(rsp_valid), 32'd0);
    chk($sformatf("v%0d rsp_ok held", idx), 32'(rsp_ok), 32'(v.ok));
    chk($sformatf("v%0d rsp_rdata held", idx), rsp_rdata, v.exp_rd);
  endtask

  initial begin
    int   n;
    logic seen;
    //          wr  addr       wdata         aw w   b    ar   r  bresp rdata        lat ok to exp_rd       ph
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 0, 0,   0,   0,   0, 1'b1, 32'h0,        5,  1, 0, 32'h0,        1};
    vecs[1] = '{1'b0, 32'h10, 32'h0,        0, 0,   0,   0,   0, 1'b1, 32'hDEADBEEF, 4,  1, 0, 32'hDEADBEEF, 1};
    vecs[2] = '{1'b1, 32'h20, 32'h12345678, 3, 0,   0,   0,   0, 1'b1, 32'h0,        8,  1, 0, 32'h0,        4};
    vecs[3] = '{1'b1, 32'h30, 32'hA5A5A5A5, 0, 0,   0,   0,   0, 1'b0, 32'h0,        5,  0, 0, 32'h0,        1};
    vecs[4] = '{1'b0, 32'h40, 32'h0,        0, 0,   0,   255, 0, 1'b1, 32'h55555555, 10, 0, 1, 32'h0,        8};
    vecs[5] = '{1'b0, 32'h44, 32'h0,        0, 0,   0,   1,   2, 1'b1, 32'hCAFEF00D, 7,  1, 0, 32'hCAFEF00D, 2};
    vecs[6] = '{1'b1, 32'h48, 32'h0BADF00D, 0, 2,   1,   0,   0, 1'b1, 32'h0,        8,  1, 0, 32'h0,        1};
    vecs[7] = '{1'b1, 32'h4C, 32'h77778888, 0, 0,   255, 0,   0, 1'b1, 32'h0,        12, 0, 1, 32'h0,        1};
    vecs[8] = '{1'b0, 32'h50, 32'h0,        0, 0,   0,   7,   0, 1'b1, 32'h11112222, 11, 1, 0, 32'h11112222, 8};

    aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;
    bresp_v = 1'b1; rdata_v = '0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    areset_n = 1'b0;
    repeat (3) @(negedge aclk);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset channel strobes", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    chk("reset rsp flags", {29'd0, rsp_valid, rsp_ok, rsp_timeout}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset awaddr", awaddr, 32'd0);
    chk("reset wdata", wdata, 32'd0);
    chk("reset araddr", araddr, 32'd0);
    areset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset while in W: transaction abandoned with no response pulse.
    aw_d = 0; w_d = 255; b_d = 0;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h13579BDF;
    seen = 0; n = 0;
    while (n < 10 && !seen) begin
      @(negedge aclk);
      n++;
      cmd_valid = 1'b0;
      if (wvalid) seen = 1;
    end
    chk("mid reset reached W", 32'(seen), 32'd1);
    areset_n = 1'b0;
    @(negedge aclk);
    chk("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid reset wvalid", 32'(wvalid), 32'd0);
    chk("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid reset awaddr", awaddr, 32'd0);
    areset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge aclk);
      if (rsp_valid || !cmd_ready) seen = 1;
    end
    chk("post reset quiet idle", 32'(seen), 32'd0);

    // Machine still usable after the abandoned write.
    w_d = 0;
    run_vec(vecs[0], 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_master.md
AXI_SRAM_MASTER -- requirements
Module: axi_sram_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, wait-state cycle limit per channel phase (0 = no timeout).
REQ-002 SHALL have port aclk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port areset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request from local client.
REQ-005 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  input  32  target address.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_ok  output  1  1 = slave reported OK.
REQ-011 SHALL have port rsp_timeout  output  1  1 = phase timed out.
REQ-012 SHALL have port rsp_rdata  output  32  read data (0 for writes/timeouts).
REQ-013 SHALL have ports awaddr output 32, awvalid output 1, awready input 1: write address channel.
REQ-014 SHALL have ports wdata output 32, wvalid output 1, wready input 1: write data channel.
REQ-015 SHALL have ports bvalid input 1, bresp input 1 (1 = OK), bready output 1: write response channel.
REQ-016 SHALL have ports araddr output 32, arvalid output 1, arready input 1: read address channel.
REQ-017 SHALL have ports rdata input 32, rvalid input 1, rready output 1: read data channel.

Function
REQ-018 SHALL implement FSM states IDLE, AW, W, B, AR, R, RSP; one command in flight at a time.
REQ-019 SHALL assert cmd_ready only in IDLE; on cmd_valid & cmd_ready, SHALL register addr/wdata/cmd_write and enter AW (write) or AR (read) on the next cycle.
REQ-020 SHALL drive awvalid=1 in AW, wvalid=1 in W, bready=1 in B, arvalid=1 in AR, rready=1 in R; all other channel outputs 0; all outputs registered or decoded from state only, never from inputs.
REQ-021 SHALL hold awaddr/wdata/araddr stable from command acceptance until the matching handshake completes.
REQ-022 SHALL issue AW and W strictly in sequence: AW -> W only after awready sampled 1 while awvalid=1; W -> B after wready sampled 1.
REQ-023 B SHALL exit to RSP on bvalid=1, capturing rsp_ok=bresp, rsp_rdata=0.
REQ-024 AR SHALL exit to R on arready=1; R SHALL exit to RSP on rvalid=1, capturing rsp_rdata=rdata, rsp_ok=1.
REQ-025 RSP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; rsp_ok/rsp_timeout/rsp_rdata SHALL hold until the next RSP.
REQ-026 SHALL keep a 16-bit wait counter, cleared on every state entry, incremented each cycle in AW/W/B/AR/R without handshake.
REQ-027 When TIMEOUT!=0 and counter reaches TIMEOUT, SHALL deassert the channel valid/ready, enter RSP with rsp_timeout=1, rsp_ok=0, rsp_rdata=0.
REQ-028 Handshake and timeout in the same cycle: handshake SHALL win.
REQ-029 Minimum latency: write = 5 cycles accept-to-rsp_valid (zero-wait slave), read = 4 cycles.
REQ-030 cmd_valid while not in IDLE SHALL be ignored (client must hold it).

Reset
REQ-031 With areset_n=0 at a rising edge, SHALL enter IDLE, clear counter, set all valid/ready outputs 0 except cmd_ready=1, rsp_ok=0, rsp_timeout=0, rsp_rdata=0, address/data outputs 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no rsp_valid pulse.

Verification
REQ-033 Write addr 0x10 data 0xDEADBEEF, slave ready immediately, bresp=1 -> AW/W/B single-cycle handshakes, rsp_valid 5 cycles after accept, rsp_ok=1.
REQ-034 Read addr 0x10 after above, rvalid with rdata 0xDEADBEEF -> rsp_rdata=0xDEADBEEF, rsp_ok=1, rsp_timeout=0.
REQ-035 awready delayed 3 cycles -> awvalid/awaddr stable 4 cycles, wvalid not asserted before AW handshake.
REQ-036 TIMEOUT=8, slave never asserts arready -> arvalid drops after 8 cycles, rsp_valid with rsp_timeout=1, rsp_ok=0.
REQ-037 bresp=0 on write -> rsp_ok=0, rsp_timeout=0.
REQ-038 areset_n low during W state -> next cycle cmd_ready=1, wvalid=0, no rsp_valid pulse.
